// File: rtl/spongent_if.sv
// spongent_if: message-in and digest-out valid/ready channels of spongent_control
interface spongent_if #(
    parameter int RATE = 8
);
    logic            msg_valid, msg_ready, msg_last, out_valid, out_ready;
    logic [RATE-1:0] msg_data, digest_data;
    modport master (output msg_valid, msg_data, msg_last, out_ready, input msg_ready, out_valid, digest_data);
    modport slave  (input msg_valid, msg_data, msg_last, out_ready, output msg_ready, out_valid, digest_data);
endinterface

// File: rtl/spongent_control.sv
// spongent_control: sequencing FSM driving the SPONGENT absorb/squeeze datapath
module spongent_control #(
    parameter int RATE        = 8,
    parameter int HASH_BLOCKS = 16,
    parameter int ROUND_LIMIT = 127
) (
    input  logic            clk,
    input  logic            rst_n,
    spongent_if.slave       bus,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic [RATE-1:0] dp_data_in,
    input  logic [RATE-1:0] dp_data_out,
    output logic            reset_state,
    output logic            sample_state,
    output logic            init_lfsr,
    output logic            update_lfsr,
    output logic            select_message,
    input  logic            lfsr_all_1
);
    localparam int CW = $clog2(ROUND_LIMIT + 1);
    localparam int BW = HASH_BLOCKS > 1 ? $clog2(HASH_BLOCKS) : 1;
    typedef enum logic [2:0] {IDLE, CLEAR, WAIT_MSG, ABS_ROUND, SQZ_OUT, SQZ_ROUND, ERROR} state_t;
    state_t          state, state_nx;
    logic [CW-1:0]   round_cnt;
    logic [BW-1:0]   blk_cnt;
    logic [RATE-1:0] msg_reg;
    logic            last_reg, first_round, done_q;
    logic            msg_hs, out_hs, in_round, last_blk, wd_hit;
    assign msg_hs         = state == WAIT_MSG && bus.msg_valid;
    assign out_hs         = state == SQZ_OUT && bus.out_ready;
    assign in_round       = state == ABS_ROUND || state == SQZ_ROUND;
    assign last_blk       = blk_cnt == BW'(HASH_BLOCKS - 1);
    assign wd_hit         = round_cnt == CW'(ROUND_LIMIT - 1);
    assign bus.msg_ready  = state == WAIT_MSG;
    assign bus.out_valid  = state == SQZ_OUT;
    assign bus.digest_data = state == SQZ_OUT ? dp_data_out : '0;
    assign busy           = state != IDLE && state != ERROR;
    assign error          = state == ERROR;
    assign done           = done_q;
    assign dp_data_in     = msg_reg;
    assign reset_state    = state == CLEAR;
    assign sample_state   = in_round;
    assign update_lfsr    = in_round;
    assign select_message = state == ABS_ROUND && first_round;
    assign init_lfsr      = msg_hs || (out_hs && !last_blk);
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, ERROR: state_nx = start ? CLEAR : state;
            CLEAR:       state_nx = WAIT_MSG;
            WAIT_MSG:    state_nx = msg_hs ? ABS_ROUND : WAIT_MSG;
            ABS_ROUND:   state_nx = lfsr_all_1 ? (last_reg ? SQZ_OUT : WAIT_MSG) : wd_hit ? ERROR : ABS_ROUND;
            SQZ_OUT:     state_nx = out_hs ? (last_blk ? IDLE : SQZ_ROUND) : SQZ_OUT;
            SQZ_ROUND:   state_nx = lfsr_all_1 ? SQZ_OUT : wd_hit ? ERROR : SQZ_ROUND;
            default:     state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            round_cnt   <= '0;
            blk_cnt     <= '0;
            msg_reg     <= '0;
            last_reg    <= 1'b0;
            first_round <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_nx;
            round_cnt   <= in_round ? round_cnt + 1'b1 : '0;
            blk_cnt     <= (state == CLEAR || state == ABS_ROUND) ? '0 : out_hs ? blk_cnt + 1'b1 : blk_cnt;
            first_round <= msg_hs;
            done_q      <= out_hs && last_blk;
            if (msg_hs) begin
                msg_reg  <= bus.msg_data;
                last_reg <= bus.msg_last;
            end
        end
    end
endmodule

// File: tb/tb_spongent_control.sv
// tb_spongent_control: randomized hashes against a mock datapath and a block-level hash model
module tb_spongent_control;
    localparam int RATE = 8, HB = 16, RL = 127;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic busy, done, error, reset_state, sample_state, init_lfsr, update_lfsr, select_message, lfsr_all_1;
    logic [RATE-1:0] dp_data_in, dp_data_out, dps, cur_blk;
    logic [RATE-1:0] blk [8];
    int cyc, lcnt, r_tgt, checks, errors;
    int n_samp, n_rst, n_sel, n_done, sel_bad, inv_bad, t_rst;

    spongent_if #(.RATE(RATE)) bus();
    spongent_control #(.RATE(RATE), .HASH_BLOCKS(HB), .ROUND_LIMIT(RL)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .start(start), .busy(busy), .done(done), .error(error),
        .dp_data_in(dp_data_in), .dp_data_out(dp_data_out), .reset_state(reset_state),
        .sample_state(sample_state), .init_lfsr(init_lfsr), .update_lfsr(update_lfsr),
        .select_message(select_message), .lfsr_all_1(lfsr_all_1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] rf(input logic [7:0] s, input int r);
        return {s[6:0], s[7]} ^ 8'(r * 29 + 7);
    endfunction

    // mock datapath: state cleared only by reset_state, round index from the lfsr stand-in
    always @(posedge clk) begin
        if (reset_state) dps <= '0;
        else if (sample_state) dps <= rf(dps ^ (select_message ? dp_data_in : 8'h00), lcnt);
        if (init_lfsr) lcnt <= 0;
        else if (update_lfsr) lcnt <= lcnt + 1;
    end
    assign dp_data_out = dps;
    assign lfsr_all_1  = lcnt == r_tgt - 1;

    always @(negedge clk) begin
        n_samp += int'(sample_state);
        n_rst  += int'(reset_state);
        n_sel  += int'(select_message);
        n_done += int'(done);
        if (reset_state && t_rst < 0) t_rst = cyc;
        if (select_message && dp_data_in !== cur_blk) sel_bad++;
        if ((sample_state && reset_state) || (bus.msg_ready && bus.out_valid) || (sample_state && bus.msg_ready)) inv_bad++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_mon();
        n_samp = 0; n_rst = 0; n_sel = 0; n_done = 0; sel_bad = 0; inv_bad = 0; t_rst = -1;
    endtask

    function automatic logic [25:0] all_outs();
        return {bus.msg_ready, bus.out_valid, bus.digest_data, busy, done, error, dp_data_in,
                reset_state, sample_state, init_lfsr, update_lfsr, select_message};
    endfunction

    task automatic send_blk(input logic [7:0] d, input logic last, output int ths);
        int to = 0;
        bus.msg_valid = 1'b1; bus.msg_data = d; bus.msg_last = last;
        @(negedge clk);
        while (!bus.msg_ready && to < 400) begin to++; @(negedge clk); end
        chk("msg_hs", bus.msg_ready, 1);
        cur_blk = d; ths = cyc;
        @(posedge clk); #1 bus.msg_valid = 1'b0;
    endtask

    task automatic do_hash(input int r, input int nb, input int gap, input int bp_blk, input int bp_len, input bit poke);
        logic [7:0] s, d0;
        logic [7:0] dig [HB];
        int t0, ths, tprev, to, stall_bad;
        r_tgt = r; s = '0;
        for (int b = 0; b < nb; b++) begin
            s ^= blk[b];
            for (int k = 0; k < r; k++) s = rf(s, k);
        end
        dig[0] = s;
        for (int i = 1; i < HB; i++) begin
            for (int k = 0; k < r; k++) s = rf(s, k);
            dig[i] = s;
        end
        clr_mon();
        @(posedge clk); #1 start = 1'b1; t0 = cyc;
        @(posedge clk); #1 start = 1'b0;
        for (int b = 0; b < nb; b++) begin
            if (b > 0) for (int g = 0; g < gap; g++) begin start = poke; @(posedge clk); #1; end
            start = 1'b0;
            send_blk(blk[b], b == nb - 1, ths);
            if (b == 0) chk("hs_lat", ths - t0, 2);
        end
        tprev = ths;
        for (int i = 0; i < HB; i++) begin
            bus.out_ready = i != bp_blk;
            to = 0;
            @(negedge clk);
            while (!bus.out_valid && to < 400) begin to++; @(negedge clk); end
            chk("out_valid", bus.out_valid, 1);
            chk($sformatf("blk_lat%0d", i), cyc - tprev, r + 1);
            if (i == bp_blk) begin
                d0 = bus.digest_data; stall_bad = 0;
                repeat (bp_len) begin
                    @(negedge clk);
                    if (!bus.out_valid || bus.digest_data !== d0 || sample_state || update_lfsr || init_lfsr) stall_bad++;
                end
                chk("stall", stall_bad, 0);
                bus.out_ready = 1'b1;
            end
            chk($sformatf("dig%0d", i), bus.digest_data, dig[i]);
            tprev = cyc;
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("done_busy", {done, busy}, 2'b10);
        @(posedge clk); #1;
        @(negedge clk);
        chk("n_done", n_done, 1);
        chk("n_samp", n_samp, (nb + HB - 1) * r);
        chk("n_sel", n_sel, nb);
        chk("sel_data", sel_bad, 0);
        chk("invariants", inv_bad, 0);
        chk("n_rst", n_rst, 1);
        chk("rst_cyc", t_rst - t0, 1);
    endtask

    initial begin
        int ths, to;
        bus.msg_valid = 1'b0; bus.msg_data = '0; bus.msg_last = 1'b0; bus.out_ready = 1'b1;
        clr_mon();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", all_outs(), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        blk[0] = 8'h80;
        do_hash(70, 1, 0, -1, 0, 1'b0);

        blk[0] = 8'h12; blk[1] = 8'h34; blk[2] = 8'h80;
        do_hash($urandom_range(20, 40), 3, 3, -1, 0, 1'b1);

        blk[0] = 8'($urandom);
        do_hash($urandom_range(10, 30), 1, 0, 3, 5, 1'b0);

        r_tgt = 0; clr_mon();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        send_blk(8'($urandom), 1'b1, ths);
        to = 0;
        @(negedge clk);
        while (!error && to < 300) begin to++; @(negedge clk); end
        chk("wd_err", error, 1);
        chk("wd_lat", cyc - ths, RL + 1);
        chk("wd_samp", n_samp, RL);
        chk("wd_outs", {busy, reset_state, sample_state, update_lfsr, init_lfsr, select_message, bus.msg_ready, bus.out_valid}, 0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("wd_restart", {error, reset_state, busy}, 3'b011);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;

        blk[0] = 8'($urandom);
        do_hash(1, 1, 0, -1, 0, 1'b0);

        r_tgt = 70; clr_mon();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        send_blk(8'($urandom), 1'b1, ths);
        to = 0;
        @(negedge clk);
        while (n_samp < 30 && to < 100) begin to++; @(negedge clk); end
        chk("mid_rounds", n_samp, 30);
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_outs", all_outs(), 0);
        blk[0] = 8'($urandom);
        do_hash(5, 1, 0, -1, 0, 1'b0);

        for (int k = 0; k < 3; k++) begin
            int nb;
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) blk[b] = 8'($urandom);
            do_hash($urandom_range(1, 20), nb, $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(1, 4), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
